run_sequencer: RTL

Synthesizable start/done sequencer for a device under test. It issues a programmable number of one-cycle `start` pulses, waits for the DUT's `done` after each one, bounds each wait with a timeout, and tallies passes and failures. It replaces free-running testbench initial blocks: it sits between the clock/reset source and the DUT's start/done pins, and its counters are readable at end of run.

---
 rtl/run_sequencer_pkg.sv | 18 +
 rtl/run_timer.sv | 37 +++
 rtl/run_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/run_sequencer_pkg.sv
// Shared types and helpers for the run_sequencer block.
package run_sequencer_pkg;

  // Sequencer states; the encoding is also exported on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int width_for(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/run_timer.sv
// Loadable up-counter with a terminal-count flag. A load restarts the count
// at zero; the count then climbs by one per cycle and parks at the limit.
module run_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: restart on load, otherwise advance until the limit is hit.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (!tc_o) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == limit_i);

endmodule

// File: rtl/run_sequencer.sv
// Start/done sequencer: issues RUNS one-cycle start pulses, waits up to
// TIMEOUT cycles for done after each, idles GAP cycles between transactions
// and tallies passes and timeouts in saturating counters.
// Optional feature macro: RUN_SEQUENCER_STOP_ON_FAIL_EN -- when defined, the
// first timeout ends the sequence immediately.
//
// Handshake: start is a single-cycle pulse; done is sampled only in WAIT, as a
// level on every rising edge, so a held level and a one-cycle pulse behave the
// same. done during START or GAP is ignored.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int RUNS    = 4,
  parameter int TIMEOUT = 100,
  parameter int GAP     = 2,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         go,
  output logic                         start,
  input  logic                         done,
  output logic                         busy,
  output logic                         finished,
  output logic [CNT_W-1:0]             pass_count,
  output logic [CNT_W-1:0]             fail_count,
  output logic [width_for(RUNS)-1:0]   run_idx,
  output logic [2:0]                   state_dbg
);

  localparam int TMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int TW   = width_for(TMAX);
  localparam int RW   = width_for(RUNS);
  localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LIM  = TW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [RW-1:0] RUN_LAST = RW'(RUNS - 1);

  state_e           state_q;
  logic             start_q;
  logic             busy_q;
  logic             finished_q;
  logic [CNT_W-1:0] pass_q;
  logic [CNT_W-1:0] fail_q;
  logic [RW-1:0]    idx_q;

  logic             tmr_tc;
  logic             tmr_load;
  logic [TW-1:0]    tmr_limit;
  logic             wait_end;
  logic             gap_end;
  logic             seq_step;
  logic             stop_fail;

  // Decode the end of each timed phase and steer the shared timer.
  always_comb begin
    wait_end  = (state_q == ST_WAIT) && (done || tmr_tc);
    gap_end   = (state_q == ST_GAP) && tmr_tc;
    // With no gap the transaction ends as soon as WAIT resolves.
    seq_step  = (GAP == 0) ? wait_end : gap_end;
`ifdef RUN_SEQUENCER_STOP_ON_FAIL_EN
    stop_fail = (state_q == ST_WAIT) && !done && tmr_tc;
`else
    stop_fail = 1'b0;
`endif
    // Hold the timer at zero outside the timed states and reload it on every
    // phase exit, so it starts from zero when WAIT or GAP is entered.
    tmr_load  = !((state_q == ST_WAIT) || (state_q == ST_GAP)) || wait_end || gap_end;
    tmr_limit = (state_q == ST_GAP) ? GAP_LIM : TO_LIM;
  end

  run_timer #(
    .W(TW)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .limit_i(tmr_limit),
    .tc_o   (tmr_tc)
  );

  // Sequencer FSM with registered outputs and saturating tallies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      pass_q     <= '0;
      fail_q     <= '0;
      idx_q      <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_FINISH: begin
          if (go) begin
            pass_q     <= '0;
            fail_q     <= '0;
            idx_q      <= '0;
            start_q    <= 1'b1;
            busy_q     <= 1'b1;
            finished_q <= 1'b0;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // done on the expiry edge still wins: it is tested first.
          if (done) begin
            if (pass_q != '1) pass_q <= pass_q + 1'b1;
          end else if (tmr_tc) begin
            if (fail_q != '1) fail_q <= fail_q + 1'b1;
          end
          if (wait_end) state_q <= ST_GAP;
        end
        ST_GAP: begin
          state_q <= ST_GAP;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      // End of a transaction: either the sequence is over or the next run
      // starts. Overrides the WAIT->GAP move when GAP is zero.
      if (seq_step || stop_fail) begin
        if ((idx_q == RUN_LAST) || stop_fail) begin
          state_q    <= ST_FINISH;
          busy_q     <= 1'b0;
          finished_q <= 1'b1;
        end else begin
          idx_q   <= idx_q + 1'b1;
          start_q <= 1'b1;
          state_q <= ST_START;
        end
      end
    end
  end

  assign start      = start_q;
  assign busy       = busy_q;
  assign finished   = finished_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign run_idx    = idx_q;
  assign state_dbg  = state_q;

endmodule
